// File: rtl/div_seq_pkg.sv
// Shared types and constants for the divider sequencer: state encoding,
// divider phase codes and divider status codes.
package div_seq_pkg;

  localparam int DEF_ITER_CYCLES = 30;
  localparam int DEF_CNT_W       = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_EVAL  = 3'd2,
    S_INIT  = 3'd3,
    S_ITER  = 3'd4,
    S_FINAL = 3'd5,
    S_WB    = 3'd6
  } state_e;

  localparam logic [1:0] PH_CHECK = 2'b00;
  localparam logic [1:0] PH_INIT  = 2'b01;
  localparam logic [1:0] PH_ITER  = 2'b10;
  localparam logic [1:0] PH_FINAL = 2'b11;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_DONE = 2'b01;
  localparam logic [1:0] ST_ZERO = 2'b10;

  // EVAL and WB keep the divider parked in its CHECK/idle phase.
  function automatic logic [1:0] phase_of(state_e s);
    case (s)
      S_INIT:  return PH_INIT;
      S_ITER:  return PH_ITER;
      S_FINAL: return PH_FINAL;
      default: return PH_CHECK;
    endcase
  endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// Bundle between control unit / divider and the sequencer.
// Optional ProtoErr flag is present when DIV_SEQ_STATUS_CHECK_EN is defined.
interface div_sequencer_if;
  import div_seq_pkg::*;

  // Start is a one-cycle request, accepted only while Busy is low;
  // there is no ready/ack, a Start seen while Busy is simply dropped.
  logic        Start;
  logic [1:0]  DivStatus;
  logic [31:0] DivHi;
  logic [31:0] DivLo;
  logic        HiWrite;
  logic        LoWrite;
  logic [31:0] HiIn;
  logic [31:0] LoIn;
  logic [1:0]  DivState;
  logic [31:0] HiOut;
  logic [31:0] LoOut;
  logic        Busy;
  logic        Done;
  logic        DivZero;
  state_e      dbg_state;
`ifdef DIV_SEQ_STATUS_CHECK_EN
  logic        ProtoErr;

  modport slave (
    input  Start, DivStatus, DivHi, DivLo, HiWrite, LoWrite, HiIn, LoIn,
    output DivState, HiOut, LoOut, Busy, Done, DivZero, dbg_state, ProtoErr
  );
  modport master (
    output Start, DivStatus, DivHi, DivLo, HiWrite, LoWrite, HiIn, LoIn,
    input  DivState, HiOut, LoOut, Busy, Done, DivZero, dbg_state, ProtoErr
  );
`else
  modport slave (
    input  Start, DivStatus, DivHi, DivLo, HiWrite, LoWrite, HiIn, LoIn,
    output DivState, HiOut, LoOut, Busy, Done, DivZero, dbg_state
  );
  modport master (
    output Start, DivStatus, DivHi, DivLo, HiWrite, LoWrite, HiIn, LoIn,
    input  DivState, HiOut, LoOut, Busy, Done, DivZero, dbg_state
  );
`endif
endinterface

// File: rtl/div_sequencer_hilo_regs.sv
// Architectural HI/LO pair: division capture wins over mthi/mtlo writes.
module hilo_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic        cap_en,
  input  logic [31:0] cap_hi,
  input  logic [31:0] cap_lo,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (cap_en) begin
      hi_d = cap_hi;
      lo_d = cap_lo;
    end else begin
      if (hi_we) hi_d = hi_in;
      if (lo_we) lo_d = lo_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;
endmodule

// File: rtl/div_sequencer.sv
// Walks the iterative divider through CHECK/INIT/ITER/FINAL and captures HI/LO.
// Define DIV_SEQ_STATUS_CHECK_EN to add the sticky ProtoErr status checker.
module div_sequencer
  import div_seq_pkg::*;
#(
  parameter int ITER_CYCLES = DEF_ITER_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic            Clock,
  input  logic            Reset,
  div_sequencer_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             zero_q, zero_d;
  logic             idle;

  assign idle = (state_q == S_IDLE);

  // Progress is driven purely by our own counter; DivStatus only matters in EVAL.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    zero_d  = 1'b0;
    case (state_q)
      S_IDLE:  if (bus.Start) state_d = S_CHECK;
      S_CHECK: state_d = S_EVAL;
      S_EVAL: begin
        if (bus.DivStatus == ST_ZERO) begin
          state_d = S_IDLE;
          zero_d  = 1'b1;
        end else begin
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        cnt_d   = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        if (cnt_q == CNT_LAST) state_d = S_FINAL;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      S_FINAL: state_d = S_WB;
      S_WB: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.DivState  = phase_of(state_q);
  assign bus.Busy      = !idle;
  assign bus.Done      = done_q;
  assign bus.DivZero   = zero_q;
  assign bus.dbg_state = state_q;

`ifdef DIV_SEQ_STATUS_CHECK_EN
  logic proto_q, proto_d;

  always_comb begin
    proto_d = proto_q;
    if (state_q == S_WB && bus.DivStatus != ST_DONE) proto_d = 1'b1;
    if ((state_q == S_ITER || state_q == S_FINAL) && bus.DivStatus == ST_ZERO)
      proto_d = 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (Reset) proto_q <= 1'b0;
    else       proto_q <= proto_d;
  end

  assign bus.ProtoErr = proto_q;
`endif

  hilo_regs u_hilo (
    .clk    (Clock),
    .rst    (Reset),
    .cap_en (state_q == S_WB),
    .cap_hi (bus.DivHi),
    .cap_lo (bus.DivLo),
    .hi_we  (bus.HiWrite && idle),
    .lo_we  (bus.LoWrite && idle),
    .hi_in  (bus.HiIn),
    .lo_in  (bus.LoIn),
    .hi_out (bus.HiOut),
    .lo_out (bus.LoOut)
  );
endmodule

// File: doc/div_sequencer.md
# div_sequencer

Sequencer between the main control unit and the iterative signed divider. Accepts a one-cycle start request, walks the divider through its CHECK/INIT/ITER/FINAL phases with its own iteration counter, traps divide-by-zero, and captures the quotient/remainder into the architectural HI/LO registers. HI/LO are also written by mthi/mtlo from the control unit when no division is in flight.

## Interface
- ITER_CYCLES, 30: number of cycles the divider is held in ITER phase
- CNT_W, 5: iteration counter width, must hold ITER_CYCLES-1

- Clock  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high
- Start  in  1  one-cycle division request from control
- DivStatus  in  2  divider status: 00 running/ok, 10 divide-by-zero, 01 iterations done
- DivHi  in  32  divider remainder output
- DivLo  in  32  divider quotient output
- HiWrite / LoWrite  in  1 each  mthi / mtlo strobes
- HiIn / LoIn  in  32 each  mthi / mtlo data
- DivState  out  2  phase code to divider: 00 CHECK, 01 INIT, 10 ITER, 11 FINAL
- HiOut / LoOut  out  32 each  architectural HI / LO
- Busy  out  1  division in flight (state != IDLE)
- Done  out  1  one-cycle pulse, HI/LO just updated by a division
- DivZero  out  1  one-cycle pulse, division aborted, divider was zero

## Operation
- States: IDLE, CHECK, EVAL, INIT, ITER, FINAL, WB.
- IDLE: DivState=00; Start=1 -> CHECK.
- CHECK: DivState=00 (divider registers zero test) -> EVAL.
- EVAL: DivState=00; DivStatus==10 -> IDLE with DivZero pulse, HI/LO untouched; else -> INIT.
- INIT: DivState=01; counter cleared -> ITER.
- ITER: DivState=10; counter increments; at count ITER_CYCLES-1 -> FINAL.
- FINAL: DivState=11 (divider writes Hi/Lo at end of cycle) -> WB.
- WB: DivState=00; HiOut<=DivHi, LoOut<=DivLo, Done<=1 -> IDLE.
- Sequencing uses own counter only; DivStatus==01 is not required for progress.
- mthi/mtlo honoured only in IDLE; ignored while Busy. Start and HiWrite/LoWrite together in IDLE: write takes effect and division starts; WB later overwrites both.
- Start while Busy: ignored, no queueing.
- Reset (any state, including mid-ITER): state IDLE, counter 0, HiOut=LoOut=0, DivState=00, Busy=Done=DivZero=0; sticky flags cleared.

## Timing
- All outputs registered or decoded from registered state; no combinational input-to-output paths.
- Start sampled at edge E0: CHECK after E0, EVAL after E1, INIT after E2, ITER E3..E33 (30 cycles), FINAL after E33, WB after E34.
- Successful division: HiOut/LoOut updated and Done=1 after E35; Busy falls after E35; next Start accepted at E35 edge-sampled cycle onward (Start in the Done cycle is accepted).
- Divide-by-zero: DivStatus valid after E1; DivZero=1 and Busy=0 after E2, single cycle.
- Done and DivZero never both high.

## Configuration
- DIV_SEQ_STATUS_CHECK_EN defined: adds output ProtoErr (1 bit, sticky until Reset). Set when, in WB, DivStatus!=01 (divider did not report completion), or when DivStatus==10 is seen in ITER/FINAL. Division still completes normally.
- Not defined: no ProtoErr port, no status checks after EVAL.

## Structure
- Package div_seq_pkg: state enum, phase constants (PH_CHECK=00, PH_INIT=01, PH_ITER=10, PH_FINAL=11), status constants (ST_OK=00, ST_DONE=01, ST_ZERO=10).
- Sub-module hilo_regs: HI/LO register pair with priority division-capture > mthi/mtlo, synchronous reset to 0.

## Test plan
- Dividend 100, Divider 7 with behavioural divider, Start at E0 -> after E35 LoOut=14, HiOut=2, Done one cycle, Busy high E0..E35.
- Dividend -7, Divider 2 -> LoOut=0xFFFFFFFD, HiOut=0xFFFFFFFF after E35.
- HI=0xAA preloaded via mthi, Divider 0 -> DivZero after E2 only, HiOut stays 0xAA, DivState never leaves 00.
- Start and HiWrite(0x55) pulsed at E10 mid-division -> both ignored, result of first division unchanged, single Done.
- Reset asserted during ITER (E20) -> after that edge state IDLE, HiOut=LoOut=0, DivState=00; new Start completes in 35 cycles.
- DIV_SEQ_STATUS_CHECK_EN defined, divider model never drives 01 -> ProtoErr=1 after E35, remains until Reset.
